nand_rr_sched: RTL and testbench

Round-robin scheduler that time-shares a single `nand2` gate instance among N requesters. Each requester submits a W-bit operand pair. The block grants one requester at a time and streams the operand bits through the shared `nand2` LSB-first, one bit per clock. It returns the W-bit bitwise NAND with the requester's index over a valid/ready response channel. This is the sequencing and arbitration layer above the gate-level primitives, and the first clocked consumer of `nand2`.

---
 rtl/nand_sched_pkg.sv | 22 ++
 rtl/nand2.sv | 11 +
 rtl/nand_rr_sched.sv | 156 +++++++++++++++
 tb/tb_nand_rr_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_sched_pkg.sv
// Shared types and width helpers for the round-robin nand2 scheduler.
// Holds the FSM state encoding and the pointer/counter width functions
// used to size registers from the N and W parameters.
package nand_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Requester pointer / grant id width; at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit-serial position counter width; at least one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/nand2.sv
// Two-input NAND primitive; purely combinational, zero cycles, no flow control.
// Ports: in1, in2 operands; out = ~(in1 & in2).
module nand2 (
  output logic out,
  input  logic in1,
  input  logic in2
);

  assign out = ~(in1 & in2);

endmodule

// File: rtl/nand_rr_sched.sv
// Round-robin scheduler time-sharing one nand2 among N requesters, LSB-first bit-serial.
// Latency: resp_valid rises W edges after the accept edge; one request per W+2 cycles at best.
// Backpressure: response held in RESP until resp_ready; no new request is accepted while busy.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot-or-zero, combinational
//   req_a/req_b           packed W-bit operands, requester i at [i*W +: W]
//   resp_valid/resp_ready response handshake; resp_data = a NAND b, resp_id = granted index
module nand_rr_sched
  import nand_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [W-1:0]         resp_data,
  output logic [$clog2(N)-1:0] resp_id
);

  localparam int PTR_W = ptr_w(N);
  localparam int CNT_W = cnt_w(W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
  localparam logic [PTR_W-1:0] LAST_ID  = PTR_W'(N - 1);

  sched_state_t     state_q,      state_d;
  logic [PTR_W-1:0] rr_ptr_q,     rr_ptr_d;
  logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [W-1:0]     result_q,     result_d;
  logic [PTR_W-1:0] grant_id_q,   grant_id_d;
  logic [W-1:0]     op_a_q,       op_a_d;
  logic [W-1:0]     op_b_q,       op_b_d;
  logic             resp_valid_q, resp_valid_d;

  // Per-requester operand views of the packed input buses.
  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*W +: W];
    assign b_arr[gi] = req_b[gi*W +: W];
  end

  // Round-robin pick: walk offsets from the top down so the smallest
  // offset from rr_ptr that has a valid request is the one that sticks.
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand_idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_idx = PTR_W'((int'(rr_ptr_q) + k) % N);
      if (req_valid[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // The single shared gate; every result bit is taken from its output.
  logic nand_in1;
  logic nand_in2;
  logic nand_out;

  assign nand_in1 = op_a_q[bit_cnt_q];
  assign nand_in2 = op_b_q[bit_cnt_q];

  nand2 u_nand (
    .out (nand_out),
    .in1 (nand_in1),
    .in2 (nand_in2)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    bit_cnt_d    = bit_cnt_q;
    result_d     = result_q;
    grant_id_d   = grant_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_valid_d = resp_valid_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          req_ready[pick_idx] = 1'b1;
          op_a_d              = a_arr[pick_idx];
          op_b_d              = b_arr[pick_idx];
          grant_id_d          = pick_idx;
          bit_cnt_d           = '0;
          result_d            = '0;
          state_d             = EVAL;
        end
      end
      EVAL: begin
        result_d[bit_cnt_q] = nand_out;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d    = '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (grant_id_q == LAST_ID) ? '0 : grant_id_q + PTR_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept strobe during reset would be lost, so never raise one.
    req_ready = req_ready & {N{rst_n}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      bit_cnt_q    <= '0;
      result_q     <= '0;
      grant_id_q   <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      bit_cnt_q    <= bit_cnt_d;
      result_q     <= result_d;
      grant_id_q   <= grant_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = result_q;
  assign resp_id    = grant_id_q;

endmodule

// File: tb/tb_nand_rr_sched.sv
// Bench for nand_rr_sched: a reference model predicts grants and results,
// a separate monitor checks responses against the expectation queue.
module tb_nand_rr_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*W-1:0]       req_a;
  logic [N*W-1:0]       req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [W-1:0]         resp_data;
  logic [$clog2(N)-1:0] resp_id;

  nand_rr_sched #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [$clog2(N)-1:0] id;
    logic [W-1:0]         data;
    int                   acc;
  } exp_t;

  exp_t q[$];

  // Reference model: idle/busy, pointer, first-valid-at-or-after-pointer pick.
  logic mbusy = 1'b0;
  int   mptr  = 0;
  int   mgid  = 0;

  always @(negedge clk) begin
    int g;
    int j;
    logic [N-1:0] oh;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    exp_t e;
    if (!rst_n) begin
      chk("req_ready_in_reset", req_ready, '0);
      mbusy = 1'b0;
      mptr  = 0;
      q.delete();
    end else if (!mbusy) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
      if (g < 0) begin
        chk("req_ready_idle_none", req_ready, '0);
      end else begin
        oh    = '0;
        oh[g] = 1'b1;
        chk("req_ready_grant", req_ready, oh);
        av     = req_a[g*W +: W];
        bv     = req_b[g*W +: W];
        e.id   = g[$clog2(N)-1:0];
        e.data = ~(av & bv);
        e.acc  = cyc;
        q.push_back(e);
        mgid  = g;
        mbusy = 1'b1;
      end
    end else begin
      chk("req_ready_busy", req_ready, '0);
      if (resp_valid && resp_ready) begin
        mbusy = 1'b0;
        mptr  = (mgid + 1) % N;
      end
    end
  end

  // Monitor: compares every presented response with the queue head.
  logic seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (q.size() == 0) begin
      chk("no_resp_expected", resp_valid, 0);
    end else if (resp_valid) begin
      if (!seen) begin
        chk("resp_latency", cyc - q[0].acc, W + 1);
        seen = 1'b1;
      end
      chk("resp_data", resp_data, q[0].data);
      chk("resp_id", resp_id, q[0].id);
      if (resp_ready) begin
        void'(q.pop_front());
        seen = 1'b0;
      end
    end else if (seen) begin
      chk("resp_held", resp_valid, 1);
      void'(q.pop_front());
      seen = 1'b0;
    end else if (cyc - q[0].acc > W + 1) begin
      chk("resp_on_time", resp_valid, 1);
      void'(q.pop_front());
    end
  end

  // Requester driver state.
  int           cnt [N];
  logic         rand_rdy;
  logic [N-1:0] last_acc;
  logic [N-1:0] snap_rr;
  logic         snap_rv;
  logic [W-1:0] snap_rd;
  logic [$clog2(N)-1:0] snap_rid;

  task automatic step();
    @(negedge clk);
    snap_rr  = req_ready;
    snap_rv  = resp_valid;
    snap_rd  = resp_data;
    snap_rid = resp_id;
    last_acc = req_ready & {N{rst_n}};
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_acc[i]) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          cnt[i]       = 0;
          req_valid[i] = 1'b0;
        end else begin
          req_a[i*W +: W] = W'($urandom);
          req_b[i*W +: W] = W'($urandom);
        end
      end
    end
    if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic present(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    cnt[i]          = n;
    req_valid[i]    = 1'b1;
  endtask

  function automatic logic all_done();
    logic d;
    d = (q.size() == 0) && !mbusy;
    for (int i = 0; i < N; i++) if (cnt[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while (!all_done() && c < maxc) begin
      step();
      c++;
    end
    chk(name, all_done(), 1);
  endtask

  task automatic wait_acc(input int i, input string name);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!last_acc[i] && c < 50);
    chk(name, last_acc[i], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    rand_rdy   = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;

    step();
    step();
    chk("reset_resp_valid", snap_rv, 0);
    chk("reset_resp_data", snap_rd, 0);
    chk("reset_resp_id", snap_rid, 0);
    chk("reset_req_ready", snap_rr, 0);
    rst_n = 1'b1;
    step();

    // Single request on requester 0.
    present(0, 8'hF0, 8'hCC, 1);
    drain("drain_single", 100);

    // Truth coverage on requester 2.
    present(2, 8'h55, 8'h33, 1);
    drain("drain_truth0", 100);
    present(2, 8'hFF, 8'hFF, 1);
    drain("drain_truth1", 100);
    present(2, 8'h00, 8'h00, 1);
    drain("drain_truth2", 100);

    // Move the pointer to 0, then all four requesters contend: 0,1,2,3,0.
    present(3, 8'hA5, 8'h0F, 1);
    drain("drain_ptr_wrap", 100);
    present(0, 8'h12, 8'h34, 2);
    present(1, 8'h56, 8'h78, 1);
    present(2, 8'h9A, 8'hBC, 1);
    present(3, 8'hDE, 8'hF0, 1);
    drain("drain_all_four", 200);

    // Pointer now 1; single grant to 3 returns it to 0, then 1 and 3 alternate.
    present(3, 8'h3C, 8'hC3, 1);
    drain("drain_ptr_reset", 100);
    present(1, W'($urandom), W'($urandom), 2);
    present(3, W'($urandom), W'($urandom), 2);
    drain("drain_fairness", 200);

    // Backpressure: hold the response for several cycles.
    present(0, 8'h6B, 8'hD2, 1);
    wait_acc(0, "bp_accept");
    resp_ready = 1'b0;
    begin
      int c;
      c = 0;
      do begin
        step();
        c++;
      end while (!snap_rv && c < 30);
      chk("bp_resp_seen", snap_rv, 1);
    end
    for (int k = 0; k < 4; k++) step();
    resp_ready = 1'b1;
    drain("drain_backpressure", 100);

    // Reset mid-EVAL: pointer is 3 after a grant to 2; drop the grant to 3.
    present(2, 8'h81, 8'h18, 1);
    drain("drain_pre_reset", 100);
    present(3, W'($urandom), W'($urandom), 2);
    wait_acc(3, "rst_first_accept");
    step();
    step();
    step();
    rst_n = 1'b0;
    present(1, W'($urandom), W'($urandom), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_resp_valid", snap_rv, 0);
    chk("post_rst_resp_data", snap_rd, 0);
    chk("post_rst_resp_id", snap_rid, 0);
    chk("post_rst_grant_ptr0", last_acc, 4'b0010);
    drain("drain_after_reset", 200);

    // Randomized contention with random response backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < N; i++) present(i, W'($urandom), W'($urandom), int'($urandom_range(1, 5)));
    drain("drain_random", 3000);
    rand_rdy   = 1'b0;
    resp_ready = 1'b1;
    step();
    step();

    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
